// File: rtl/wb_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter_pkg
// Shared definitions for the two-port Wishbone master controller:
//   - wba_state_e    : controller state encoding (IDLE, IF_RD, MEM_RD, RMW_RD,
//                      MEM_WR)
//   - RST_ENABLE     : active level of the synchronous reset
//   - ZERO_WORD      : all-zero data word
//   - WB_SELECT_FULL : byte-select pattern that marks a full-word access
//   - LANE_W         : width of one Wishbone byte lane
// -----------------------------------------------------------------------------
package wb_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    WBA_IDLE   = 3'd0,
    WBA_IF_RD  = 3'd1,
    WBA_MEM_RD = 3'd2,
    WBA_RMW_RD = 3'd3,
    WBA_MEM_WR = 3'd4
  } wba_state_e;

  localparam logic        RST_ENABLE     = 1'b1;
  localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
  localparam logic [3:0]  WB_SELECT_FULL = 4'b1111;
  localparam int          LANE_W         = 8;

endpackage : wb_bus_arbiter_pkg

// File: rtl/wb_bus_arbiter_lane_merge.sv
// -----------------------------------------------------------------------------
// wb_lane_merge
// Combinational byte-lane merge used by the read-modify-write store path.
// Lanes with sel_i set take the new store data; the others keep the word
// just read from the bus.
//   sel_i    : byte-lane enables of the store
//   new_i    : lane-aligned store data
//   old_i    : word read back from memory
//   merged_o : word to write back
// -----------------------------------------------------------------------------
module wb_lane_merge
  import wb_bus_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W/LANE_W-1:0] sel_i,
  input  logic [DATA_W-1:0]        new_i,
  input  logic [DATA_W-1:0]        old_i,
  output logic [DATA_W-1:0]        merged_o
);

  always_comb begin
    for (int b = 0; b < DATA_W / LANE_W; b++) begin
      merged_o[LANE_W*b +: LANE_W] = sel_i[b] ? new_i[LANE_W*b +: LANE_W]
                                              : old_i[LANE_W*b +: LANE_W];
    end
  end

endmodule : wb_lane_merge

// File: rtl/wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter
// Shares one Wishbone classic bus between the instruction-fetch (IF) port and
// the data-memory (MEM) port. MEM wins simultaneous requests. Sub-word stores
// are done as read-modify-write. Every bus and completion output is
// registered; the stall requests are combinational.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   flush_i                  : pipeline flush (discards an in-flight fetch)
//   if_req_i / if_addr_i     : fetch request and address
//   if_data_o / if_done_o    : fetched word, one-cycle completion strobe
//   stall_req_if             : IF stall request toward pipeline control
//   mem_req_i / mem_we_i     : MEM request, write enable
//   mem_addr_i / mem_sel_i   : MEM address, byte-lane enables
//   mem_data_i               : lane-aligned store data
//   mem_data_o / mem_done_o  : load data, one-cycle completion strobe
//   stall_req_mem            : MEM stall request toward pipeline control
//   wb_*                     : Wishbone master interface
// -----------------------------------------------------------------------------
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     if_req_i,
  input  logic [ADDR_W-1:0]        if_addr_i,
  output logic [DATA_W-1:0]        if_data_o,
  output logic                     if_done_o,
  output logic                     stall_req_if,
  input  logic                     mem_req_i,
  input  logic                     mem_we_i,
  input  logic [ADDR_W-1:0]        mem_addr_i,
  input  logic [DATA_W/LANE_W-1:0] mem_sel_i,
  input  logic [DATA_W-1:0]        mem_data_i,
  output logic [DATA_W-1:0]        mem_data_o,
  output logic                     mem_done_o,
  output logic                     stall_req_mem,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [ADDR_W-1:0]        wb_adr_o,
  output logic [DATA_W/LANE_W-1:0] wb_sel_o,
  output logic [DATA_W-1:0]        wb_dat_o,
  input  logic [DATA_W-1:0]        wb_dat_i,
  input  logic                     wb_ack_i
);

  localparam int SEL_W = DATA_W / LANE_W;

  wba_state_e         state_q, state_d;
  logic               cyc_q, we_q;
  logic [ADDR_W-1:0]  adr_q;
  logic [SEL_W-1:0]   sel_out_q;
  logic [SEL_W-1:0]   req_sel_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  if_data_q, mem_data_q;
  logic               if_done_q, mem_done_q;
  logic               flushed_q;
  logic [DATA_W-1:0]  merged;

  wb_lane_merge #(.DATA_W(DATA_W)) u_lane_merge (
    .sel_i    (req_sel_q),
    .new_i    (wdata_q),
    .old_i    (wb_dat_i),
    .merged_o (merged)
  );

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WBA_IDLE: begin
        if (mem_req_i) begin
          if (!mem_we_i)              state_d = WBA_MEM_RD;
          else if (mem_sel_i == '1)   state_d = WBA_MEM_WR;
          else                        state_d = WBA_RMW_RD;
        end else if (if_req_i && !flush_i) begin
          state_d = WBA_IF_RD;
        end
      end
      WBA_IF_RD, WBA_MEM_RD, WBA_MEM_WR: if (wb_ack_i) state_d = WBA_IDLE;
      WBA_RMW_RD:                        if (wb_ack_i) state_d = WBA_MEM_WR;
      default:                           state_d = WBA_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state_q <= WBA_IDLE;
    else                   state_q <= state_d;
  end

  // Bus outputs are derived from the next state so they are registered yet
  // line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      sel_out_q  <= '0;
      req_sel_q  <= '0;
      wdata_q    <= '0;
      if_data_q  <= '0;
      mem_data_q <= '0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      flushed_q  <= 1'b0;
    end else begin
      cyc_q      <= (state_d != WBA_IDLE);
      we_q       <= (state_d == WBA_MEM_WR);
      sel_out_q  <= '1;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;

      // Request attributes are frozen here; later input changes are ignored.
      if (state_q == WBA_IDLE && state_d != WBA_IDLE) begin
        adr_q     <= (state_d == WBA_IF_RD) ? if_addr_i : mem_addr_i;
        req_sel_q <= mem_sel_i;
        wdata_q   <= mem_data_i;
        flushed_q <= 1'b0;
      end

      unique case (state_q)
        WBA_IF_RD: begin
          if (wb_ack_i) begin
            // A flush at any point of the fetch, including the ack cycle,
            // lets the bus cycle finish but drops the returned word.
            if (!(flushed_q || flush_i)) begin
              if_data_q <= wb_dat_i;
              if_done_q <= 1'b1;
            end
          end else if (flush_i) begin
            flushed_q <= 1'b1;
          end
        end
        WBA_MEM_RD: begin
          if (wb_ack_i) begin
            mem_data_q <= wb_dat_i;
            mem_done_q <= 1'b1;
          end
        end
        WBA_RMW_RD: if (wb_ack_i) wdata_q <= merged;
        WBA_MEM_WR: if (wb_ack_i) mem_done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign wb_we_o       = we_q;
  assign wb_adr_o      = adr_q;
  assign wb_sel_o      = sel_out_q;
  assign wb_dat_o      = wdata_q;
  assign if_data_o     = if_data_q;
  assign if_done_o     = if_done_q;
  assign mem_data_o    = mem_data_q;
  assign mem_done_o    = mem_done_q;
  assign stall_req_if  = if_req_i & ~if_done_q;
  assign stall_req_mem = mem_req_i & ~mem_done_q;

endmodule : wb_bus_arbiter

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Two-port Wishbone master controller that shares the single CPU-side Wishbone bus between the instruction-fetch port and the data-memory port. It sequences each access as a registered Wishbone classic cycle, gives MEM priority over IF, and performs read-modify-write for sub-word stores. It raises per-port stall requests toward the pipeline control block and returns read data to IF and MEM.

## Interface
Parameters:
- ADDR_W, 32, Wishbone address width
- DATA_W, 32, Wishbone data width (byte lanes = DATA_W/8 = 4)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- flush_i  in  1  pipeline flush from ctrl
- if_req_i  in  1  IF fetch request (read only)
- if_addr_i  in  32  IF fetch address
- if_data_o  out  32  fetched word, valid while if_done_o
- if_done_o  out  1  one-cycle completion strobe for IF
- stall_req_if  out  1  IF stall request to ctrl
- mem_req_i  in  1  MEM access request
- mem_we_i  in  1  MEM write enable
- mem_addr_i  in  32  MEM address
- mem_sel_i  in  4  MEM byte-lane enables
- mem_data_i  in  32  MEM store data (lane-aligned)
- mem_data_o  out  32  load data, valid while mem_done_o
- mem_done_o  out  1  one-cycle completion strobe for MEM
- stall_req_mem  out  1  MEM stall request to ctrl
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_adr_o  out  32  Wishbone address
- wb_sel_o  out  4  Wishbone byte select (always 4'b1111)
- wb_dat_o  out  32  Wishbone write data
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge

## Operation
- States: IDLE, IF_RD, MEM_RD, RMW_RD, MEM_WR.
- IDLE: if mem_req_i -> MEM_RD (load), MEM_WR (store, sel==4'b1111) or RMW_RD (store, sel!=4'b1111); else if if_req_i and !flush_i -> IF_RD; else stay. MEM wins simultaneous requests.
- Address, we, sel and store data captured on the IDLE->busy transition; later input changes ignored until done.
- IF_RD / MEM_RD: cyc=stb=1, we=0. On wb_ack_i: latch wb_dat_i into the port's data register, pulse done, -> IDLE.
- RMW_RD: read of mem_addr_i. On ack: merged word = mem_data_i lanes where sel=1, wb_dat_i lanes where sel=0; -> MEM_WR; cyc and stb stay high, we rises on the same edge.
- MEM_WR: cyc=stb=we=1, dat=merged or full word. On ack: pulse mem_done_o, -> IDLE.
- stall_req_x = x_req_i & ~x_done_o (combinational from registered done); a pending-but-unserved request stalls as well.
- flush_i during IF_RD: the cycle completes on the bus, the data is discarded and if_done_o is not pulsed. flush_i never aborts MEM states.
- Reset: all outputs 0 (wb_sel_o = 0, data outputs 32'h0), state IDLE. Reset mid-cycle drops cyc/stb on the next edge. No done strobe.

## Timing
- All Wishbone outputs and done/data outputs are registered; stall outputs are combinational.
- Request seen in IDLE at cycle 0; cyc/stb high from cycle 1; with ack in cycle 1, done high in cycle 2. Minimum load/fetch latency: 2 cycles. Full store: 2 cycles. RMW store: 3 cycles.
- Each extra wait cycle of wb_ack_i adds one cycle. Holding wb_ack_i high is a slave error: at most one ack is consumed per state.
- After done, the state is IDLE for one cycle; back-to-back accesses have a 1-cycle gap with cyc low.
- wb_ack_i outside a cycle (cyc=0) is ignored.

## Structure
- Shared defines header gets state encodings (WBA_IDLE..WBA_MEM_WR), WB_SELECT_FULL=4'b1111, and the existing RstEnable/ZeroWord/Stop/NoStop macros.
- One natural sub-module: wb_lane_merge (combinational byte-lane merge: sel, new, old -> merged).

## Test plan
- Reset mid-RMW_RD -> next cycle cyc=stb=0, state IDLE, all outputs 0, no done.
- IF read 0x0000_1000 with ack in cycle 1 returning 0xDEADBEEF -> if_done_o in cycle 2, if_data_o=0xDEADBEEF, stall_req_if low in cycle 2.
- IF and MEM load requested together, MEM addr 0x80 -> MEM served first, IF cycle starts 1 cycle after mem_done_o, stall_req_if high throughout.
- Byte store sel=4'b0010, data 0x0000AB00, memory holds 0x11223344 -> read, then write 0x1122AB44 with we=1, mem_done_o after the second ack.
- Load with 3 wait cycles before ack -> cyc/stb held 4 cycles, stall_req_mem high until mem_done_o.
- flush_i asserted during IF_RD -> bus cycle completes, if_done_o never pulses, next cycle IDLE.
